// File: rtl/ms7210_init_ctrl_if.sv
// Request/completion bus between the MS7210 init sequencer and the shared I2C byte master.
interface ms7210_init_ctrl_if;
    logic        i2c_req;
    logic        i2c_rd;
    logic [15:0] i2c_addr;
    logic [7:0]  i2c_wdata;
    logic        i2c_done;
    logic        i2c_nack;
    logic [7:0]  i2c_rdata;

    modport master (output i2c_req, i2c_rd, i2c_addr, i2c_wdata,
                    input  i2c_done, i2c_nack, i2c_rdata);
    modport slave  (input  i2c_req, i2c_rd, i2c_addr, i2c_wdata,
                    output i2c_done, i2c_nack, i2c_rdata);
endinterface

// File: rtl/ms7210_init_ctrl.sv
// MS7210 power-up sequencer: holds the chip in reset, then writes the register table via the I2C master.
// Optional MS7210_VERIFY_EN: read back every accepted write and retry on mismatch.
module ms7210_init_ctrl #(
    parameter int unsigned RST_CYCLES      = 1000,
    parameter int unsigned POST_RST_CYCLES = 5000,
    parameter int unsigned CFG_NUM         = 32,
    parameter int unsigned MAX_RETRY       = 3,
    parameter int unsigned IDX_W           = 6
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    output logic               m_rstn,
    output logic [IDX_W-1:0]   cfg_idx,
    input  logic [23:0]        cfg_word,
    ms7210_init_ctrl_if.master bus,
    output logic               busy,
    output logic               inited,
    output logic               error,
    output logic [IDX_W-1:0]   err_idx
);

    localparam int unsigned CNT_MAX = (RST_CYCLES > POST_RST_CYCLES) ? RST_CYCLES : POST_RST_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_RST_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(CFG_NUM - 1);

    typedef enum logic [3:0] {
        RST_HOLD,
        RST_WAIT,
        FETCH,
        WR,
        WR_WAIT,
`ifdef MS7210_VERIFY_EN
        RD,
        RD_WAIT,
`endif
        NEXT,
        DONE,
        FAIL
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [RTY_W-1:0] rty, rty_nxt;
    logic             req, req_nxt;
    logic             rd, rd_nxt;
    logic [15:0]      addr, addr_nxt;
    logic [7:0]       wdata, wdata_nxt;
    logic             m_rstn_nxt, busy_nxt, inited_nxt, error_nxt;
    logic [IDX_W-1:0] idx_nxt, err_idx_nxt;
    logic             retry_ok;

    assign bus.i2c_req   = req;
    assign bus.i2c_rd    = rd;
    assign bus.i2c_addr  = addr;
    assign bus.i2c_wdata = wdata;
    assign retry_ok      = (rty < RTY_MAX);

`ifndef MS7210_VERIFY_EN
    logic unused_rdata;
    assign unused_rdata = ^bus.i2c_rdata;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= RST_HOLD;
            cnt     <= '0;
            rty     <= '0;
            req     <= 1'b0;
            rd      <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
            m_rstn  <= 1'b0;
            cfg_idx <= '0;
            busy    <= 1'b0;
            inited  <= 1'b0;
            error   <= 1'b0;
            err_idx <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rty     <= rty_nxt;
            req     <= req_nxt;
            rd      <= rd_nxt;
            addr    <= addr_nxt;
            wdata   <= wdata_nxt;
            m_rstn  <= m_rstn_nxt;
            cfg_idx <= idx_nxt;
            busy    <= busy_nxt;
            inited  <= inited_nxt;
            error   <= error_nxt;
            err_idx <= err_idx_nxt;
        end
    end

    // Request outputs are raised on the edge leaving WR/RD, so the bus always sees a low cycle after done.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        rty_nxt     = rty;
        req_nxt     = req;
        rd_nxt      = rd;
        addr_nxt    = addr;
        wdata_nxt   = wdata;
        m_rstn_nxt  = m_rstn;
        idx_nxt     = cfg_idx;
        busy_nxt    = busy;
        inited_nxt  = inited;
        error_nxt   = error;
        err_idx_nxt = err_idx;

        if (start) begin
            state_nxt  = RST_HOLD;
            cnt_nxt    = '0;
            rty_nxt    = '0;
            req_nxt    = 1'b0;
            rd_nxt     = 1'b0;
            m_rstn_nxt = 1'b0;
            idx_nxt    = '0;
            busy_nxt   = 1'b1;
            inited_nxt = 1'b0;
            error_nxt  = 1'b0;
        end else begin
            unique case (state)
                RST_HOLD: begin
                    m_rstn_nxt = 1'b0;
                    busy_nxt   = 1'b1;
                    if (cnt >= RST_LAST) begin
                        cnt_nxt    = '0;
                        m_rstn_nxt = 1'b1;
                        state_nxt  = RST_WAIT;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                RST_WAIT: begin
                    if (cnt >= POST_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = FETCH;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                FETCH: begin
                    addr_nxt  = cfg_word[23:8];
                    wdata_nxt = cfg_word[7:0];
                    state_nxt = WR;
                end
                WR: begin
                    req_nxt   = 1'b1;
                    rd_nxt    = 1'b0;
                    state_nxt = WR_WAIT;
                end
                WR_WAIT: begin
                    if (bus.i2c_done) begin
                        req_nxt = 1'b0;
                        if (!bus.i2c_nack) begin
`ifdef MS7210_VERIFY_EN
                            state_nxt = RD;
`else
                            state_nxt = NEXT;
`endif
                        end else if (retry_ok) begin
                            rty_nxt   = rty + RTY_W'(1);
                            state_nxt = WR;
                        end else begin
                            error_nxt   = 1'b1;
                            err_idx_nxt = cfg_idx;
                            busy_nxt    = 1'b0;
                            inited_nxt  = 1'b0;
                            state_nxt   = FAIL;
                        end
                    end
                end
`ifdef MS7210_VERIFY_EN
                RD: begin
                    req_nxt   = 1'b1;
                    rd_nxt    = 1'b1;
                    state_nxt = RD_WAIT;
                end
                RD_WAIT: begin
                    if (bus.i2c_done) begin
                        req_nxt = 1'b0;
                        rd_nxt  = 1'b0;
                        if (!bus.i2c_nack && (bus.i2c_rdata == wdata)) begin
                            state_nxt = NEXT;
                        end else if (retry_ok) begin
                            rty_nxt   = rty + RTY_W'(1);
                            state_nxt = WR;
                        end else begin
                            error_nxt   = 1'b1;
                            err_idx_nxt = cfg_idx;
                            busy_nxt    = 1'b0;
                            inited_nxt  = 1'b0;
                            state_nxt   = FAIL;
                        end
                    end
                end
`endif
                NEXT: begin
                    rty_nxt = '0;
                    if (cfg_idx == IDX_LAST) begin
                        inited_nxt = 1'b1;
                        busy_nxt   = 1'b0;
                        state_nxt  = DONE;
                    end else begin
                        idx_nxt   = cfg_idx + IDX_W'(1);
                        state_nxt = FETCH;
                    end
                end
                DONE: state_nxt = DONE;
                FAIL: state_nxt = FAIL;
                default: state_nxt = RST_HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_ms7210_init_ctrl.sv
// Bench for ms7210_init_ctrl: table-driven NACK/readback scenarios, restart corners and random runs
// compared against a transaction-list model of the expected I2C traffic.
module tb_ms7210_init_ctrl;
    localparam int unsigned RST_CYCLES      = 4;
    localparam int unsigned POST_RST_CYCLES = 3;
    localparam int unsigned CFG_NUM         = 3;
    localparam int unsigned MAX_RETRY       = 2;
    localparam int unsigned IDX_W           = 2;
`ifdef MS7210_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    typedef struct packed { logic rd; logic [15:0] addr; logic [7:0] wdata; } txn_t;
    typedef struct { int nack0, nack1, nack2, corr0; int txn_nv, txn_v; int fidx_nv, fidx_v; } vec_t;

    logic             clk, rstn, start, m_rstn, busy, inited, error;
    logic [IDX_W-1:0] cfg_idx, err_idx;
    logic [23:0]      cfg_word;
    logic [23:0]      tab [4];

    ms7210_init_ctrl_if bus ();

    ms7210_init_ctrl #(
        .RST_CYCLES(RST_CYCLES), .POST_RST_CYCLES(POST_RST_CYCLES),
        .CFG_NUM(CFG_NUM), .MAX_RETRY(MAX_RETRY), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .m_rstn(m_rstn),
        .cfg_idx(cfg_idx), .cfg_word(cfg_word), .bus(bus),
        .busy(busy), .inited(inited), .error(error), .err_idx(err_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign cfg_word = tab[cfg_idx];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   nack_plan [4];
    int   corr_plan [4];
    int   wr_cnt [4];
    int   rd_cnt [4];
    logic [7:0] mem [4];
    bit   lat_rand;
    txn_t log_q [$];
    txn_t exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural I2C master: logs each request, answers after a latency with a planned NACK/readback.
    initial begin : responder
        bit         serving, done_hi;
        int         cd, e;
        txn_t       cap, cur;
        bit         p_nack;
        logic [7:0] p_rdata;
        serving = 0; done_hi = 0; cd = 0; p_nack = 0; p_rdata = '0;
        bus.i2c_done = 1'b0; bus.i2c_nack = 1'b0; bus.i2c_rdata = '0;
        forever begin
            @(negedge clk);
            cur = {bus.i2c_rd, bus.i2c_addr, bus.i2c_wdata};
            if (done_hi) begin
                bus.i2c_done = 1'b0;
                bus.i2c_nack = 1'b0;
                done_hi = 0;
                check("req_low_after_done", 32'(bus.i2c_req), 32'd0);
            end else if (serving) begin
                if (bus.i2c_req === 1'b1) check("req_payload_stable", 32'(cur), 32'(cap));
                cd--;
                if (cd <= 0) begin
                    bus.i2c_done  = 1'b1;
                    bus.i2c_nack  = p_nack;
                    bus.i2c_rdata = p_rdata;
                    done_hi = 1;
                    serving = 0;
                end
            end else if (bus.i2c_req === 1'b1) begin
                cap = cur;
                log_q.push_back(cap);
                e = int'(cap.addr[9:8]);
                if (cap.rd) begin
                    rd_cnt[e]++;
                    p_nack  = 0;
                    p_rdata = mem[e] ^ ((rd_cnt[e] <= corr_plan[e]) ? 8'h01 : 8'h00);
                end else begin
                    wr_cnt[e]++;
                    p_nack  = (wr_cnt[e] <= nack_plan[e]);
                    p_rdata = 8'h00;
                    if (!p_nack) mem[e] = cap.wdata;
                end
                cd = lat_rand ? int'($urandom_range(1, 3)) : 1;
                serving = 1;
            end
        end
    end

    // Expected traffic: each entry retried until accepted; more than MAX_RETRY failures ends the run.
    task automatic build_exp(output int fidx);
        int fails, wn, rn;
        bit ok;
        exp_q.delete();
        fidx = -1;
        for (int e = 0; e < int'(CFG_NUM); e++) begin
            fails = 0; wn = 0; rn = 0; ok = 0;
            while (!ok && fails <= int'(MAX_RETRY)) begin
                exp_q.push_back({1'b0, tab[e]});
                wn++;
                if (wn <= nack_plan[e]) fails++;
                else if (VERIFY) begin
                    exp_q.push_back({1'b1, tab[e]});
                    rn++;
                    if (rn <= corr_plan[e]) fails++;
                    else ok = 1;
                end else ok = 1;
            end
            if (!ok) begin
                fidx = e;
                return;
            end
        end
    endtask

    task automatic fill_table();
        for (int e = 0; e < 4; e++)
            tab[e] = (e < int'(CFG_NUM)) ? {8'(e), 8'($urandom), 8'($urandom)} : 24'h0;
    endtask

    task automatic clear_run();
        log_q.delete();
        for (int e = 0; e < 4; e++) begin
            wr_cnt[e] = 0; rd_cnt[e] = 0; mem[e] = 8'h00;
        end
    endtask

    // Called on the first negedge after the sequence restarted (m_rstn already seen low once).
    task automatic check_boot();
        int low, gap;
        low = 1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (m_rstn === 1'b1) break;
            low++;
        end
        check("m_rstn_low_cycles", 32'(low), 32'(RST_CYCLES));
        gap = 0;
        for (int k = 0; k < 50; k++) begin
            if (bus.i2c_req === 1'b1) break;
            @(negedge clk);
            gap++;
        end
        check("first_req_gap", 32'(gap), 32'(POST_RST_CYCLES + 2));
        check("first_req_idx", 32'(cfg_idx), 32'd0);
        check("first_req_addr", 32'(bus.i2c_addr), 32'(tab[0][23:8]));
        check("first_req_busy", 32'(busy), 32'd1);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(negedge clk);
        check("rst_m_rstn", 32'(m_rstn), 32'd0);
        check("rst_req", 32'(bus.i2c_req), 32'd0);
        check("rst_rd", 32'(bus.i2c_rd), 32'd0);
        check("rst_addr", 32'(bus.i2c_addr), 32'd0);
        check("rst_wdata", 32'(bus.i2c_wdata), 32'd0);
        check("rst_cfg_idx", 32'(cfg_idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_inited", 32'(inited), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_err_idx", 32'(err_idx), 32'd0);
        rstn = 1'b1;
        clear_run();
        check_boot();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_req_drop", 32'(bus.i2c_req), 32'd0);
        check("start_m_rstn", 32'(m_rstn), 32'd0);
        check("start_inited", 32'(inited), 32'd0);
        check("start_error", 32'(error), 32'd0);
        check("start_busy", 32'(busy), 32'd1);
        clear_run();
        check_boot();
    endtask

    task automatic wait_end();
        bit to;
        to = 1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (inited === 1'b1 || error === 1'b1) begin
                to = 0;
                break;
            end
        end
        check("end_timeout", 32'(to), 32'd0);
    endtask

    task automatic wait_entry1_write();
        bit to;
        to = 1;
        for (int k = 0; k < 500; k++) begin
            if (bus.i2c_req === 1'b1 && bus.i2c_rd === 1'b0 && cfg_idx == IDX_W'(1)) begin
                to = 0;
                break;
            end
            @(negedge clk);
        end
        check("entry1_wait_timeout", 32'(to), 32'd0);
    endtask

    task automatic finish_run(input bit have_row, input int r_fidx, input int r_txn);
        int fidx, n;
        repeat (8) @(negedge clk);
        build_exp(fidx);
        check("end_inited", 32'(inited), 32'(fidx < 0));
        check("end_error", 32'(error), 32'(fidx >= 0));
        check("end_busy", 32'(busy), 32'd0);
        check("end_m_rstn", 32'(m_rstn), 32'd1);
        check("end_req", 32'(bus.i2c_req), 32'd0);
        if (fidx >= 0) check("end_err_idx", 32'(err_idx), 32'(fidx));
        check("txn_count", 32'(log_q.size()), 32'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("txn[%0d]", i), 32'(log_q[i]), 32'(exp_q[i]));
        if (have_row) begin
            check("row_txn_count", 32'(log_q.size()), 32'(r_txn));
            check("row_inited", 32'(inited), 32'(r_fidx < 0));
            if (r_fidx >= 0) check("row_err_idx", 32'(err_idx), 32'(r_fidx));
        end
    endtask

    task automatic clear_plan();
        for (int e = 0; e < 4; e++) begin
            nack_plan[e] = 0; corr_plan[e] = 0;
        end
    endtask

    initial begin : main
        vec_t vecs [6];
        // {nack0, nack1, nack2, corr0, txn plain, txn verify, fail idx plain, fail idx verify}
        vecs[0] = '{0, 0, 0, 0, 3, 6, -1, -1};
        vecs[1] = '{0, 2, 0, 0, 5, 8, -1, -1};
        vecs[2] = '{0, 0, 3, 0, 5, 7,  2,  2};
        vecs[3] = '{1, 0, 2, 0, 6, 9, -1, -1};
        vecs[4] = '{0, 0, 0, 1, 3, 8, -1, -1};
        vecs[5] = '{0, 0, 0, 3, 3, 6, -1,  0};

        rstn = 1'b0; start = 1'b0; lat_rand = 0;
        clear_plan();
        clear_run();
        fill_table();
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            clear_plan();
            nack_plan[0] = vecs[i].nack0;
            nack_plan[1] = vecs[i].nack1;
            nack_plan[2] = vecs[i].nack2;
            corr_plan[0] = vecs[i].corr0;
            fill_table();
            if (i == 0) do_reset();
            else pulse_start();
            wait_end();
            finish_run(1, VERIFY ? vecs[i].fidx_v : vecs[i].fidx_nv, VERIFY ? vecs[i].txn_v : vecs[i].txn_nv);
        end

        // start while entry 1 is outstanding; its done arrives during the reset hold
        clear_plan();
        fill_table();
        pulse_start();
        wait_entry1_write();
        pulse_start();
        wait_end();
        finish_run(0, 0, 0);

        // one-cycle rstn pulse mid-sequence
        fill_table();
        pulse_start();
        wait_entry1_write();
        do_reset();
        wait_end();
        finish_run(0, 0, 0);

        lat_rand = 1;
        for (int r = 0; r < 20; r++) begin
            for (int e = 0; e < int'(CFG_NUM); e++) begin
                nack_plan[e] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
                corr_plan[e] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            end
            fill_table();
            if (r % 5 == 0) do_reset();
            else pulse_start();
            wait_end();
            finish_run(0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no completion, expected end of test before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
